// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: default widths, opcode
// constants and FSM state encodings. The ALU and the testbench use them too.
package alu_pkg;

  localparam int DEFAULT_BUS_SIZE    = 8;
  localparam int DEFAULT_OPCODE_SIZE = 6;
  localparam int DEFAULT_COUNT_SIZE  = 8;

  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_ADD = 6'b100000;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_SUB = 6'b100010;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_AND = 6'b100100;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_OR  = 6'b100101;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_XOR = 6'b100110;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_NOR = 6'b100111;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_SRL = 6'b000010;
  localparam logic [DEFAULT_OPCODE_SIZE-1:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // True when the switch value names one of the eight operations the ALU implements.
  function automatic logic is_supported(input logic [DEFAULT_OPCODE_SIZE-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of board-side inputs, ALU feedback and sequencer outputs.
// The sequencer uses the slave view; the board/testbench side uses master.
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int BUS_SIZE    = DEFAULT_BUS_SIZE,
  parameter int OPCODE_SIZE = DEFAULT_OPCODE_SIZE,
  parameter int COUNT_SIZE  = DEFAULT_COUNT_SIZE
);

  logic [BUS_SIZE-1:0]    sw;
  logic                   btn_a;
  logic                   btn_b;
  logic                   btn_op;
  logic [BUS_SIZE-1:0]    alu_result;
  logic                   alu_carry;
  logic [BUS_SIZE-1:0]    num1;
  logic [BUS_SIZE-1:0]    num2;
  logic [OPCODE_SIZE-1:0] opcode;
  logic [BUS_SIZE-1:0]    result;
  logic                   carry_out;
  logic                   result_valid;
  logic                   op_error;
  logic [2:0]             state_out;
  logic [COUNT_SIZE-1:0]  op_count;

  modport slave (
    input  sw, btn_a, btn_b, btn_op, alu_result, alu_carry,
    output num1, num2, opcode, result, carry_out, result_valid,
           op_error, state_out, op_count
  );

  modport master (
    output sw, btn_a, btn_b, btn_op, alu_result, alu_carry,
    input  num1, num2, opcode, result, carry_out, result_valid,
           op_error, state_out, op_count
  );

endinterface

// File: rtl/alu_sequencer_btn_edge.sv
// Rising-edge detector for one debounced push-button. The history register
// resets to 1 so a button still held when reset releases is not a press.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic hist;

  // Remember the button level from the previous edge.
  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b1;
    else       hist <= btn;
  end

  assign press = btn & ~hist;

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller that walks operand A, operand B and the opcode from a
// shared switch bus into the ALU, then captures one result per execute press.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BUS_SIZE    = DEFAULT_BUS_SIZE,
  parameter int OPCODE_SIZE = DEFAULT_OPCODE_SIZE,
  parameter int COUNT_SIZE  = DEFAULT_COUNT_SIZE
) (
  input logic           clk,
  input logic           reset,
  alu_sequencer_if.slave bus
);

  logic press_a;
  logic press_b;
  logic press_op;
  logic take_a;
  logic take_b;
  logic take_op;
  logic op_ok;
  logic [OPCODE_SIZE-1:0] sw_op;

  state_t                 state;
  logic [BUS_SIZE-1:0]    num1_q;
  logic [BUS_SIZE-1:0]    num2_q;
  logic [OPCODE_SIZE-1:0] opcode_q;
  logic [BUS_SIZE-1:0]    result_q;
  logic                   carry_q;
  logic                   valid_q;
  logic                   error_q;
  logic [COUNT_SIZE-1:0]  count_q;

  btn_edge u_edge_a  (.clk(clk), .reset(reset), .btn(bus.btn_a),  .press(press_a));
  btn_edge u_edge_b  (.clk(clk), .reset(reset), .btn(bus.btn_b),  .press(press_b));
  btn_edge u_edge_op (.clk(clk), .reset(reset), .btn(bus.btn_op), .press(press_op));

  // Coinciding presses resolve as A over B over op; losers are simply dropped.
  assign take_a  = press_a;
  assign take_b  = press_b  & ~press_a;
  assign take_op = press_op & ~press_a & ~press_b;

  assign sw_op = bus.sw[OPCODE_SIZE-1:0];
  assign op_ok = is_supported(sw_op);

  // Sequencing FSM; every output it drives is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_A;
      num1_q   <= '0;
      num2_q   <= '0;
      opcode_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        WAIT_A: begin
          if (take_a) begin
            num1_q  <= bus.sw;
            error_q <= 1'b0;
            state   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (take_a) begin
            num1_q  <= bus.sw;
            error_q <= 1'b0;
          end else if (take_b) begin
            num2_q  <= bus.sw;
            error_q <= 1'b0;
            state   <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (take_a) begin
            num1_q  <= bus.sw;
            error_q <= 1'b0;
            state   <= WAIT_B;
          end else if (take_b) begin
            num2_q  <= bus.sw;
            error_q <= 1'b0;
          end else if (take_op) begin
            if (op_ok) begin
              opcode_q <= sw_op;
              error_q  <= 1'b0;
              state    <= EXEC;
            end else begin
              error_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          result_q <= bus.alu_result;
          carry_q  <= bus.alu_carry;
          valid_q  <= 1'b1;
          count_q  <= count_q + COUNT_SIZE'(1);
          state    <= DONE;
        end
        DONE: begin
          if (take_a) begin
            num1_q  <= bus.sw;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            state   <= WAIT_B;
          end else if (take_op) begin
            if (op_ok) begin
              opcode_q <= sw_op;
              error_q  <= 1'b0;
              state    <= EXEC;
            end else begin
              error_q  <= 1'b1;
            end
          end
        end
        default: state <= WAIT_A;
      endcase
    end
  end

  assign bus.num1         = num1_q;
  assign bus.num2         = num2_q;
  assign bus.opcode       = opcode_q;
  assign bus.result       = result_q;
  assign bus.carry_out    = carry_q;
  assign bus.result_valid = valid_q;
  assign bus.op_error     = error_q;
  assign bus.state_out    = state;
  assign bus.op_count     = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU in the loop.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [8:0] alu_wide;

  alu_sequencer_if bus ();

  alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: bit 8 is carry for ADD and borrow for SUB.
  always_comb begin
    alu_wide = '0;
    case (bus.opcode)
      OP_ADD: alu_wide = {1'b0, bus.num1} + {1'b0, bus.num2};
      OP_SUB: alu_wide = {1'b0, bus.num1} - {1'b0, bus.num2};
      OP_AND: alu_wide = {1'b0, bus.num1 & bus.num2};
      OP_OR:  alu_wide = {1'b0, bus.num1 | bus.num2};
      OP_XOR: alu_wide = {1'b0, bus.num1 ^ bus.num2};
      OP_NOR: alu_wide = {1'b0, ~(bus.num1 | bus.num2)};
      OP_SRL: alu_wide = {1'b0, bus.num1 >> bus.num2[2:0]};
      OP_SRA: alu_wide = {1'b0, $signed(bus.num1) >>> bus.num2[2:0]};
      default: alu_wide = '0;
    endcase
  end

  assign bus.alu_result = alu_wide[7:0];
  assign bus.alu_carry  = alu_wide[8];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic a, input logic b, input logic op);
    bus.sw     = s;
    bus.btn_a  = a;
    bus.btn_b  = b;
    bus.btn_op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic pressA(input logic [7:0] s);
    applyStimulus(s, 1'b1, 1'b0, 1'b0);
    applyStimulus(s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressB(input logic [7:0] s);
    applyStimulus(s, 1'b0, 1'b1, 1'b0);
    applyStimulus(s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressOp(input logic [7:0] s);
    applyStimulus(s, 1'b0, 1'b0, 1'b1);
    applyStimulus(s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.sw     = '0;
    bus.btn_a  = 1'b0;
    bus.btn_b  = 1'b0;
    bus.btn_op = 1'b0;

    doReset();
    checkOutput("rst_state", 32'(bus.state_out), 32'd0);
    checkOutput("rst_num1", 32'(bus.num1), 32'h00);
    checkOutput("rst_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("rst_count", 32'(bus.op_count), 32'd0);
    checkOutput("rst_error", 32'(bus.op_error), 32'd0);

    $display("[TB] btn_b in WAIT_A, then 0F + 01 ADD");
    pressB(8'h33);
    checkOutput("b_in_wait_a_state", 32'(bus.state_out), 32'd0);
    checkOutput("b_in_wait_a_num2", 32'(bus.num2), 32'h00);
    pressA(8'h0F);
    checkOutput("load_a_state", 32'(bus.state_out), 32'd1);
    checkOutput("load_a_num1", 32'(bus.num1), 32'h0F);
    pressB(8'h01);
    checkOutput("load_b_state", 32'(bus.state_out), 32'd2);
    applyStimulus({2'b00, OP_ADD}, 1'b0, 1'b0, 1'b1);
    checkOutput("exec_state", 32'(bus.state_out), 32'd3);
    checkOutput("exec_opcode", 32'(bus.opcode), 32'h20);
    applyStimulus({2'b00, OP_ADD}, 1'b0, 1'b0, 1'b0);
    checkOutput("add1_result", 32'(bus.result), 32'h10);
    checkOutput("add1_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("add1_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("add1_count", 32'(bus.op_count), 32'd1);
    checkOutput("add1_state", 32'(bus.state_out), 32'd4);

    $display("[TB] FF + 01 ADD, then SUB from DONE");
    doReset();
    pressA(8'hFF);
    pressB(8'h01);
    pressOp({2'b00, OP_ADD});
    checkOutput("add2_result", 32'(bus.result), 32'h00);
    checkOutput("add2_carry", 32'(bus.carry_out), 32'd1);
    pressOp({2'b00, OP_SUB});
    checkOutput("sub1_result", 32'(bus.result), 32'hFE);
    checkOutput("sub1_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("sub1_count", 32'(bus.op_count), 32'd2);

    $display("[TB] unsupported opcode then SUB");
    pressA(8'h05);
    checkOutput("reload_from_done_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("reload_from_done_state", 32'(bus.state_out), 32'd1);
    pressB(8'h07);
    pressOp(8'h3F);
    checkOutput("bad_op_error", 32'(bus.op_error), 32'd1);
    checkOutput("bad_op_state", 32'(bus.state_out), 32'd2);
    checkOutput("bad_op_opcode", 32'(bus.opcode), 32'h22);
    pressOp({2'b00, OP_SUB});
    checkOutput("sub2_error", 32'(bus.op_error), 32'd0);
    checkOutput("sub2_result", 32'(bus.result), 32'hFE);
    checkOutput("sub2_carry", 32'(bus.carry_out), 32'd1);
    checkOutput("sub2_count", 32'(bus.op_count), 32'd3);

    $display("[TB] coincident A/B presses and a held op button");
    pressA(8'h11);
    applyStimulus(8'h22, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("ab_same_num1", 32'(bus.num1), 32'h22);
    checkOutput("ab_same_num2", 32'(bus.num2), 32'h07);
    checkOutput("ab_same_state", 32'(bus.state_out), 32'd1);
    pressB(8'h09);
    for (int i = 0; i < 20; i++) applyStimulus({2'b00, OP_ADD}, 1'b0, 1'b0, 1'b1);
    applyStimulus({2'b00, OP_ADD}, 1'b0, 1'b0, 1'b0);
    checkOutput("held_op_count", 32'(bus.op_count), 32'd4);
    checkOutput("held_op_result", 32'(bus.result), 32'h2B);
    checkOutput("held_op_state", 32'(bus.state_out), 32'd4);

    $display("[TB] reset during EXEC");
    applyStimulus({2'b00, OP_SUB}, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_abort_state", 32'(bus.state_out), 32'd3);
    reset = 1'b1;
    applyStimulus({2'b00, OP_SUB}, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("abort_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("abort_count", 32'(bus.op_count), 32'd0);
    checkOutput("abort_result", 32'(bus.result), 32'h00);
    checkOutput("abort_state", 32'(bus.state_out), 32'd0);

    $display("[TB] btn_a held across reset release");
    reset = 1'b1;
    applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
    checkOutput("held_a_state", 32'(bus.state_out), 32'd0);
    checkOutput("held_a_num1", 32'(bus.num1), 32'h00);
    applyStimulus(8'h44, 1'b0, 1'b0, 1'b0);
    pressA(8'h44);
    checkOutput("repress_a_state", 32'(bus.state_out), 32'd1);
    checkOutput("repress_a_num1", 32'(bus.num1), 32'h44);

    $display("[TB] 256 operations wrap the counter");
    doReset();
    pressA(8'h01);
    pressB(8'h02);
    for (int i = 0; i < 256; i++) pressOp({2'b00, OP_ADD});
    checkOutput("wrap_count", 32'(bus.op_count), 32'h00);
    checkOutput("wrap_valid", 32'(bus.result_valid), 32'd1);
    checkOutput("wrap_result", 32'(bus.result), 32'h03);
    pressOp({2'b00, OP_AND});
    checkOutput("and_result", 32'(bus.result), 32'h00);
    checkOutput("and_count", 32'(bus.op_count), 32'd1);
    pressOp({2'b00, OP_OR});
    checkOutput("or_result", 32'(bus.result), 32'h03);
    pressOp({2'b00, OP_NOR});
    checkOutput("nor_result", 32'(bus.result), 32'hFC);
    checkOutput("nor_opcode", 32'(bus.opcode), 32'h27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
